// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_SIGNED_EN to honour sgn (two's complement operands); otherwise all ops are unsigned.
module muldiv_unit #(
   parameter int WIDTH = 16
) (
   input  logic             c,
   input  logic             r,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] OP_MULLO = 2'd0;
   localparam logic [1:0] OP_MULHI = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             zdiv_q, zdiv_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi, mul_lo;
   logic [WIDTH:0]     div_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub, div_rem, div_quo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, fin;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               zero_b;

`ifdef MULDIV_SIGNED_EN
   logic negp_q, negp_d;
   logic negr_q, negr_d;
   logic a_neg, b_neg;

   always_comb begin
      a_neg = sgn & a[WIDTH-1];
      b_neg = sgn & b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end
`else
   logic unused_sgn;
   assign unused_sgn = sgn;

   always_comb begin
      a_mag = a;
      b_mag = b;
   end
`endif

   // {hi,lo} is the product register for multiply and {remainder,dividend/quotient} for divide.
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      mul_hi  = mul_sum[WIDTH:1];
      mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
      div_sh  = {hi_q, lo_q[WIDTH-1]};
      div_ge  = (div_sh >= {1'b0, opb_q});
      div_sub = div_sh[WIDTH-1:0] - opb_q;
      div_rem = div_ge ? div_sub : div_sh[WIDTH-1:0];
      div_quo = {lo_q[WIDTH-2:0], div_ge};
      prod    = {mul_hi, mul_lo};
      quo     = div_quo;
      rem     = div_rem;
`ifdef MULDIV_SIGNED_EN
      if (negp_q) begin
         prod = -prod;
         quo  = -quo;
      end
      if (negr_q) rem = -rem;
`endif
      case (op_q)
         OP_MULLO: fin = prod[WIDTH-1:0];
         OP_MULHI: fin = prod[2*WIDTH-1:WIDTH];
         OP_DIV:   fin = quo;
         default:  fin = rem;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      zdiv_d   = zdiv_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      result_d = result_q;
      dbz_d    = dbz_q;
`ifdef MULDIV_SIGNED_EN
      negp_d   = negp_q;
      negr_d   = negr_q;
`endif
      zero_b   = op[1] && (b == '0);

      case (state_q)
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q[1]) begin
               hi_d = div_rem;
               lo_d = div_quo;
            end else begin
               hi_d = mul_hi;
               lo_d = mul_lo;
            end
            // Divide-by-zero spends a single RUN cycle; hi holds a, lo holds all-ones.
            if (zdiv_q) begin
               result_d = op_q[0] ? hi_q : lo_q;
               dbz_d    = 1'b1;
               state_d  = S_DONE;
            end else if (cnt_q == LAST) begin
               result_d = fin;
               dbz_d    = 1'b0;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (start && state_q != S_RUN) begin
         state_d = S_RUN;
         cnt_d   = '0;
         op_d    = op;
         zdiv_d  = zero_b;
         opb_d   = b_mag;
         if (zero_b) begin
            hi_d = a;
            lo_d = '1;
         end else begin
            hi_d = '0;
            lo_d = a_mag;
         end
`ifdef MULDIV_SIGNED_EN
         negp_d = a_neg ^ b_neg;
         negr_d = a_neg;
`endif
      end
   end

   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         zdiv_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         result_q <= '0;
         dbz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         negp_q   <= 1'b0;
         negr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         zdiv_q   <= zdiv_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
`ifdef MULDIV_SIGNED_EN
         negp_q   <= negp_d;
         negr_q   <= negr_d;
`endif
      end
   end

   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations queued at issue, checked when done pulses.
module tb_muldiv_unit;

   logic        c = 1'b0;
   logic        r;
   logic        start;
   logic [1:0]  op;
   logic        sgn;
   logic [15:0] a, b;
   logic        busy, done, div_by_zero;
   logic [15:0] result;

   typedef struct {
      string       tag;
      logic [15:0] res;
      logic        dz;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   int   done_cnt = 0;
   int   prev_done = 0;
   int   last_done = 0;

`ifdef MULDIV_SIGNED_EN
   localparam logic [15:0] E_SDIV = 16'hFFFD, E_SMOD = 16'hFFFF, E_SMULHI = 16'hFFFF;
   localparam logic [15:0] E_MINQ = 16'h8000, E_MINR = 16'h0000;
`else
   localparam logic [15:0] E_SDIV = 16'h7FFC, E_SMOD = 16'h0001, E_SMULHI = 16'h0001;
   localparam logic [15:0] E_MINQ = 16'h0000, E_MINR = 16'h8000;
`endif

   muldiv_unit #(.WIDTH(16)) dut (
      .c(c), .r(r), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
   );

   always #5 c = ~c;
   always @(posedge c) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] model(input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb);
      logic [31:0] p;
      logic [15:0] res;
      p = {16'h0, aa} * {16'h0, bb};
      case (o)
         2'd0:    res = p[15:0];
         2'd1:    res = p[31:16];
         2'd2:    res = (bb == 0) ? 16'hFFFF : aa / bb;
         default: res = (bb == 0) ? aa : aa % bb;
      endcase
      return {(o[1] && bb == 0), res};
   endfunction

   // Called on a falling edge; start is sampled at the next rising edge (E0).
   task automatic issue(input logic [1:0] o, input logic s, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [15:0] er, input logic ed, input int lat, input string tag, input bit push);
      exp_t e;
      op = o; sgn = s; a = aa; b = bb; start = 1'b1;
      if (push) begin
         e.tag = tag; e.res = er; e.dz = ed; e.lat = lat; e.start_cyc = cyc + 1;
         q.push_back(e);
      end
      @(negedge c);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      for (int i = 0; i < max && q.size() != 0; i++) @(negedge c);
      chk("drain", q.size(), 0);
   endtask

   task automatic wait_done(input int max);
      bit seen = 0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge c);
         seen = done;
      end
      chk("wait_done", seen, 1);
   endtask

   always @(negedge c) begin
      exp_t e;
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         prev_done = last_done;
         last_done = cyc;
         chk("busy_with_done", busy, 0);
         if (q.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            e = q.pop_front();
            chk($sformatf("%s.res", e.tag), result, e.res);
            chk($sformatf("%s.dz", e.tag), div_by_zero, e.dz);
            chk($sformatf("%s.lat", e.tag), cyc - e.start_cyc, e.lat);
            chk($sformatf("%s.busy", e.tag), busy_cnt, e.lat);
         end
         busy_cnt = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  ro;
      logic [15:0] ra, rb;
      logic [16:0] m;
      int          d0;
      r = 1'b0; start = 1'b0; op = 2'd0; sgn = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge c);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.result", result, 0);
      chk("rst.dz", div_by_zero, 0);
      r = 1'b1;
      @(negedge c);

      issue(2'd0, 0, 16'h1234, 16'h0010, 16'h2340, 0, 16, "mullo", 1);
      wait_idle(40);
      issue(2'd1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 0, 16, "mulhi_ff", 1);
      wait_idle(40);
      issue(2'd0, 0, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 16, "mullo_ff", 1);
      wait_idle(40);

      issue(2'd2, 0, 16'd1000, 16'd7, 16'd142, 0, 16, "div", 1);
      wait_done(40);
      issue(2'd3, 0, 16'd1000, 16'd7, 16'd6, 0, 16, "mod_b2b", 1);
      wait_idle(40);
      chk("b2b_gap", last_done - prev_done, 17);

      issue(2'd2, 0, 16'h1234, 16'h0000, 16'hFFFF, 1, 1, "div0", 1);
      wait_idle(10);
      issue(2'd3, 0, 16'h1234, 16'h0000, 16'h1234, 1, 1, "mod0", 1);
      wait_idle(10);

      // Start/operand churn during RUN must not disturb the in-flight multiply.
      issue(2'd0, 0, 16'h1234, 16'h0010, 16'h2340, 0, 16, "churn", 1);
      for (int i = 0; i < 10; i++) begin
         start = 1'($urandom());
         a = 16'($urandom());
         b = 16'($urandom());
         op = 2'($urandom());
         @(negedge c);
      end
      start = 1'b0;
      wait_idle(40);

      issue(2'd0, 0, 16'h1234, 16'h0010, 16'h0000, 0, 16, "abandon", 0);
      repeat (7) @(negedge c);
      r = 1'b0;
      #1;
      chk("midrst.busy", busy, 0);
      chk("midrst.done", done, 0);
      chk("midrst.result", result, 0);
      chk("midrst.dz", div_by_zero, 0);
      @(negedge c);
      r = 1'b1;
      busy_cnt = 0;
      d0 = done_cnt;
      repeat (25) @(negedge c);
      chk("midrst.no_done", done_cnt, d0);

      issue(2'd2, 1, 16'hFFF9, 16'h0002, E_SDIV, 0, 16, "sdiv", 1);
      wait_idle(40);
      issue(2'd3, 1, 16'hFFF9, 16'h0002, E_SMOD, 0, 16, "smod", 1);
      wait_idle(40);
      issue(2'd1, 1, 16'hFFFF, 16'h0002, E_SMULHI, 0, 16, "smulhi", 1);
      wait_idle(40);
      issue(2'd2, 1, 16'h8000, 16'hFFFF, E_MINQ, 0, 16, "sminq", 1);
      wait_idle(40);
      issue(2'd3, 1, 16'h8000, 16'hFFFF, E_MINR, 0, 16, "sminr", 1);
      wait_idle(40);
      issue(2'd2, 1, 16'hFFF9, 16'h0000, 16'hFFFF, 1, 1, "sdiv0", 1);
      wait_idle(10);
      issue(2'd3, 1, 16'hFFF9, 16'h0000, 16'hFFF9, 1, 1, "smod0", 1);
      wait_idle(10);

      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom());
         ra = 16'($urandom());
         rb = (i == 5) ? 16'h0000 : 16'($urandom() >> (i * 2));
         m  = model(ro, ra, rb);
         issue(ro, 0, ra, rb, m[15:0], m[16], m[16] ? 1 : 16, $sformatf("rand%0d", i), 1);
         wait_idle(40);
      end

      repeat (3) @(negedge c);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
